// File: rtl/trig_rate_limiter_pkg.sv
// Shared types and helpers for the trigger rate limiter.
package trig_rate_limiter_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ARMED    = 2'd1,
      HOLDOFF  = 2'd2
   } state_t;

   localparam int CNT_W = 32;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      return (inc && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/trig_rate_limiter_if.sv
// AXI4-Stream style trigger channel (data/valid/ready).
interface trig_rate_limiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/trig_rl_fifo.sv
// Small first-word-fall-through FIFO; head word and valid come straight from registers.
module trig_rl_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_rd,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [CW-1:0]         o_count
);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [CW-1:0]         r_count;
   logic                  w_wr;
   logic                  w_rd;

   assign o_full  = (r_count == CW'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];
   assign w_wr    = i_wr && !o_full;
   assign w_rd    = i_rd && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

endmodule

// File: rtl/trig_rate_limiter.sv
// Trigger holdoff + per-window quota limiter; excess triggers are dropped and counted.
module trig_rate_limiter
   import trig_rate_limiter_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int HOLDOFF_BITS = 16,
   parameter int WINDOW_BITS  = 20,
   parameter int QUOTA_BITS   = 8
) (
   input  logic                    ifclk,
   input  logic                    rst_i,
   input  logic                    runrst_i,
   input  logic                    enable_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic [WINDOW_BITS-1:0]  window_len_i,
   input  logic [QUOTA_BITS-1:0]   max_count_i,
   trig_rate_limiter_if.slave      s_trig,
   trig_rate_limiter_if.master     m_trig,
   output logic [CNT_W-1:0]        accepted_count_o,
   output logic [CNT_W-1:0]        dropped_count_o,
   output logic                    holdoff_active_o
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   state_t                  r_state, w_state_nxt;
   logic [HOLDOFF_BITS-1:0] r_ho_cnt, w_ho_nxt;
   logic [WINDOW_BITS-1:0]  r_win_tmr, w_tmr_nxt;
   logic [QUOTA_BITS-1:0]   r_win_cnt, w_wcnt_nxt;
   logic [CNT_W-1:0]        r_acc, r_drp;

   logic           w_full, w_empty;
   logic [FCW-1:0] w_unused_count;
   logic           w_quota_ok, w_terminal, w_accept, w_drop;

   assign w_quota_ok = (max_count_i == '0) || (window_len_i == '0) || (r_win_cnt < max_count_i);
   // Also catches window_len_i == 0 and a window shortened below the running timer.
   assign w_terminal = ({1'b0, r_win_tmr} + (WINDOW_BITS+1)'(1)) >= {1'b0, window_len_i};
   assign w_accept   = !runrst_i && enable_i && (r_state == ARMED) && s_trig.tvalid
                       && w_quota_ok && !w_full;
   assign w_drop     = !runrst_i && enable_i && s_trig.tvalid && !w_accept;

   always_comb begin
      w_state_nxt = r_state;
      w_ho_nxt    = r_ho_cnt;
      w_tmr_nxt   = r_win_tmr;
      w_wcnt_nxt  = r_win_cnt;
      if (runrst_i || !enable_i) begin
         w_state_nxt = (runrst_i && enable_i) ? ARMED : DISABLED;
         w_ho_nxt    = '0;
         w_tmr_nxt   = '0;
         w_wcnt_nxt  = '0;
      end else begin
         case (r_state)
            DISABLED: w_state_nxt = ARMED;
            ARMED: begin
               if (w_accept && (holdoff_i != '0)) begin
                  w_state_nxt = HOLDOFF;
                  w_ho_nxt    = holdoff_i;
               end
            end
            HOLDOFF: begin
               w_ho_nxt = r_ho_cnt - HOLDOFF_BITS'(1);
               if (r_ho_cnt == HOLDOFF_BITS'(1)) w_state_nxt = ARMED;
            end
            default: w_state_nxt = DISABLED;
         endcase
         if (r_state != DISABLED) begin
            if (w_terminal) begin
               w_tmr_nxt  = '0;
               w_wcnt_nxt = '0;
            end else begin
               w_tmr_nxt  = r_win_tmr + WINDOW_BITS'(1);
               w_wcnt_nxt = (w_accept && (r_win_cnt != '1)) ? r_win_cnt + QUOTA_BITS'(1) : r_win_cnt;
            end
         end
      end
   end

   always_ff @(posedge ifclk or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= DISABLED;
         r_ho_cnt  <= '0;
         r_win_tmr <= '0;
         r_win_cnt <= '0;
         r_acc     <= '0;
         r_drp     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ho_cnt  <= w_ho_nxt;
         r_win_tmr <= w_tmr_nxt;
         r_win_cnt <= w_wcnt_nxt;
         if (runrst_i) begin
            r_acc <= '0;
            r_drp <= '0;
         end else begin
            r_acc <= sat_inc(r_acc, w_accept);
            r_drp <= sat_inc(r_drp, w_drop);
         end
      end
   end

   trig_rl_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (ifclk),
      .rst    (rst_i),
      .i_clr  (runrst_i),
      .i_wr   (w_accept),
      .i_wdata(s_trig.tdata),
      .i_rd   (m_trig.tready),
      .o_rdata(m_trig.tdata),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_count(w_unused_count)
   );

   assign m_trig.tvalid    = !w_empty;
   assign s_trig.tready    = 1'b1;
   assign accepted_count_o = r_acc;
   assign dropped_count_o  = r_drp;
   assign holdoff_active_o = (r_state == HOLDOFF);

endmodule

// File: tb/tb_trig_rate_limiter.sv
// Directed plus randomized check of trig_rate_limiter against a cycle-numbered reference model.
module tb_trig_rate_limiter;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic        ifclk = 1'b0;
   logic        rst_i = 1'b0;
   logic        runrst_i = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] holdoff_i = '0;
   logic [19:0] window_len_i = '0;
   logic [7:0]  max_count_i = '0;
   logic [31:0] acc_o, drp_o;
   logic        hact_o;

   trig_rate_limiter_if #(.DATA_WIDTH(DW)) s_if ();
   trig_rate_limiter_if #(.DATA_WIDTH(DW)) m_if ();

   trig_rate_limiter #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .HOLDOFF_BITS(16), .WINDOW_BITS(20), .QUOTA_BITS(8)
   ) dut (
      .ifclk(ifclk), .rst_i(rst_i), .runrst_i(runrst_i), .enable_i(enable_i),
      .holdoff_i(holdoff_i), .window_len_i(window_len_i), .max_count_i(max_count_i),
      .s_trig(s_if), .m_trig(m_if),
      .accepted_count_o(acc_o), .dropped_count_o(drp_o), .holdoff_active_o(hact_o)
   );

   always #5 ifclk = ~ifclk;

   // Reference model: holdoff as an absolute "earliest next accept" cycle, window as a position.
   int          n_pass = 0, n_chk = 0;
   longint      cyc = 0, next_ok = 0;
   bit          m_on = 0;
   int          wpos = 0, wused = 0;
   longint      macc = 0, mdrp = 0;
   logic [31:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete(); macc = 0; mdrp = 0; wpos = 0; wused = 0; next_ok = 0; m_on = 0;
   endtask

   task automatic model_step();
      int  sz;
      bit  acc, quota;
      sz = q.size();
      if (runrst_i) begin
         model_reset();
         m_on = enable_i;
      end else begin
         if (sz > 0 && m_if.tready) void'(q.pop_front());
         if (!enable_i) begin
            m_on = 0; wpos = 0; wused = 0; next_ok = 0;
         end else if (!m_on) begin
            if (s_if.tvalid) mdrp++;
            m_on = 1;
         end else begin
            quota = (window_len_i == 0) || (max_count_i == 0) || (wused < int'(max_count_i));
            acc   = s_if.tvalid && (cyc >= next_ok) && quota && (sz < DEPTH);
            if (acc) begin
               q.push_back(s_if.tdata);
               macc++;
               next_ok = cyc + longint'(holdoff_i) + 1;
            end else if (s_if.tvalid) mdrp++;
            if (window_len_i == 0 || wpos + 1 >= int'(window_len_i)) begin
               wpos = 0; wused = 0;
            end else begin
               wpos++; wused += int'(acc);
            end
         end
      end
      cyc++;
   endtask

   task automatic compare_all();
      chk("tvalid", 32'(m_if.tvalid), 32'(q.size() != 0));
      if (q.size() != 0) chk("tdata", m_if.tdata, q[0]);
      chk("accepted", acc_o, macc[31:0]);
      chk("dropped", drp_o, mdrp[31:0]);
      chk("holdoff_active", 32'(hact_o), 32'(m_on && (cyc < next_ok)));
      chk("s_tready", 32'(s_if.tready), 32'd1);
   endtask

   task automatic step();
      @(posedge ifclk);
      model_step();
      @(negedge ifclk);
      compare_all();
   endtask

   task automatic run_reset();
      runrst_i = 1'b1;
      step();
      runrst_i = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tvalid"}, 32'(m_if.tvalid), 32'd0);
      chk({tag, "_tdata"}, m_if.tdata, 32'd0);
      chk({tag, "_acc"}, acc_o, 32'd0);
      chk({tag, "_drp"}, drp_o, 32'd0);
      chk({tag, "_hact"}, 32'(hact_o), 32'd0);
      chk({tag, "_tready"}, 32'(s_if.tready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
      #1 rst_i = 1'b1;
      repeat (2) @(negedge ifclk);
      chk_reset_vals("por");
      rst_i = 1'b0;
      model_reset();
      enable_i = 1'b1;

      // holdoff = 3: accepts at 0,4,8
      holdoff_i = 16'd3;
      run_reset();
      for (int i = 0; i < 10; i++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 32'(i); step();
      end
      s_if.tvalid = 1'b0;
      chk("ho_accepted", acc_o, 32'd3);
      chk("ho_dropped", drp_o, 32'd7);
      step();

      // quota 2 per 16-cycle window: accepts at 0,1,16,17
      holdoff_i = 16'd0; window_len_i = 20'd16; max_count_i = 8'd2;
      run_reset();
      for (int i = 0; i < 32; i++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 32'(i); step();
      end
      s_if.tvalid = 1'b0;
      chk("quota_accepted", acc_o, 32'd4);
      chk("quota_dropped", drp_o, 32'd28);
      step();
      window_len_i = '0; max_count_i = '0;

      // backpressure: FIFO holds 4, rest dropped, then drains in order
      m_if.tready = 1'b0;
      run_reset();
      for (int i = 0; i < 6; i++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 32'(i); step();
      end
      s_if.tvalid = 1'b0;
      chk("bp_accepted", acc_o, 32'd4);
      chk("bp_dropped", drp_o, 32'd2);
      chk("bp_head", m_if.tdata, 32'd0);
      m_if.tready = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // run reset with queued words while in holdoff
      m_if.tready = 1'b0;
      run_reset();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) holdoff_i = 16'd100;
         s_if.tvalid = 1'b1; s_if.tdata = 32'h100 + 32'(i); step();
      end
      s_if.tvalid = 1'b0;
      step();
      chk("rr_hact_before", 32'(hact_o), 32'd1);
      run_reset();
      chk("rr_tvalid", 32'(m_if.tvalid), 32'd0);
      chk("rr_acc", acc_o, 32'd0);
      s_if.tvalid = 1'b1; s_if.tdata = 32'h200; step();
      s_if.tvalid = 1'b0;
      chk("rr_beat_accepted", acc_o, 32'd1);
      m_if.tready = 1'b1;
      step(); step();

      // disable drains FIFO without counting input
      holdoff_i = 16'd0; m_if.tready = 1'b0;
      run_reset();
      for (int i = 0; i < 2; i++) begin
         s_if.tvalid = 1'b1; s_if.tdata = 32'h300 + 32'(i); step();
      end
      enable_i = 1'b0; m_if.tready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      s_if.tvalid = 1'b0;
      chk("dis_accepted", acc_o, 32'd2);
      chk("dis_dropped", drp_o, 32'd0);
      chk("dis_drained", 32'(m_if.tvalid), 32'd0);
      enable_i = 1'b1;
      run_reset();

      // randomized traffic with config changes, enable toggles and run resets
      for (int i = 0; i < 1500; i++) begin
         s_if.tvalid = ($urandom_range(0, 99) < 60);
         s_if.tdata  = $urandom;
         m_if.tready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) == 0) begin
            holdoff_i    = 16'($urandom_range(0, 5));
            window_len_i = 20'($urandom_range(0, 12));
            max_count_i  = 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 99) < 2) enable_i = ~enable_i;
         runrst_i = ($urandom_range(0, 149) == 0);
         step();
      end
      runrst_i = 1'b0;

      // asynchronous reset in the middle of traffic
      enable_i = 1'b1; holdoff_i = '0; window_len_i = '0; max_count_i = '0;
      m_if.tready = 1'b0; s_if.tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_if.tdata = 32'h400 + 32'(i); step();
      end
      @(posedge ifclk);
      model_step();
      #2 rst_i = 1'b1;
      #1 chk_reset_vals("async");
      model_reset();
      @(negedge ifclk);
      rst_i = 1'b0;
      s_if.tdata = 32'h500;
      step();
      chk("post_rst_drop", drp_o, 32'd1);
      chk("post_rst_acc", acc_o, 32'd0);
      step();
      chk("post_rst_accept", acc_o, 32'd1);
      s_if.tvalid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
